// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: MEM/WB pipeline stage with valid/ready handshake, one-entry
// skid buffer, flush, and a write-back forwarding tap.
//
// Ports:
//   clk, rst                clock and asynchronous active-high reset
//   flush                   discard held and incoming entries
//   in_valid/in_ready       upstream handshake (in_ready depends on state only)
//   in_wb/alu/rdata/dst     incoming entry payload
//   out_valid/out_ready     downstream handshake
//   out_wb/alu/rdata/dst    main entry payload
//   fwd_valid/dst/data      forwarding tap derived from the main entry
//   occupancy               number of held entries (0..2)
module mem_wb_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned WB_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WB_W-1:0]   in_wb,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_rdata,
    input  logic [REG_W-1:0]  in_dst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WB_W-1:0]   out_wb,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_rdata,
    output logic [REG_W-1:0]  out_dst,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_dst,
    output logic [DATA_W-1:0] fwd_data,
    output logic [1:0]        occupancy
);

    // Main entry (M) drives the outputs; skid entry (S) absorbs one stall.
    logic              r_m_valid;
    logic [WB_W-1:0]   r_m_wb;
    logic [DATA_W-1:0] r_m_alu;
    logic [DATA_W-1:0] r_m_rdata;
    logic [REG_W-1:0]  r_m_dst;

    logic              r_s_valid;
    logic [WB_W-1:0]   r_s_wb;
    logic [DATA_W-1:0] r_s_alu;
    logic [DATA_W-1:0] r_s_rdata;
    logic [REG_W-1:0]  r_s_dst;

    logic w_accept;
    logic w_drain;
    logic w_m_free;

    // Ready only while the skid slot is empty, so it never depends on out_ready.
    assign in_ready = !r_s_valid && !rst;
    assign w_accept = in_valid && in_ready && !flush;
    assign w_drain  = r_m_valid && out_ready;
    assign w_m_free = !r_m_valid || w_drain;

    // Entry storage: skid has priority into M so FIFO order is preserved.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_wb    <= '0;
            r_m_alu   <= '0;
            r_m_rdata <= '0;
            r_m_dst   <= '0;
            r_s_valid <= 1'b0;
            r_s_wb    <= '0;
            r_s_alu   <= '0;
            r_s_rdata <= '0;
            r_s_dst   <= '0;
        end else if (flush) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
            r_m_wb    <= '0;
            r_s_wb    <= '0;
        end else if (w_m_free) begin
            if (r_s_valid) begin
                r_m_valid <= 1'b1;
                r_m_wb    <= r_s_wb;
                r_m_alu   <= r_s_alu;
                r_m_rdata <= r_s_rdata;
                r_m_dst   <= r_s_dst;
                r_s_valid <= 1'b0;
            end else if (w_accept) begin
                r_m_valid <= 1'b1;
                r_m_wb    <= in_wb;
                r_m_alu   <= in_alu;
                r_m_rdata <= in_rdata;
                r_m_dst   <= in_dst;
            end else begin
                r_m_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_s_valid <= 1'b1;
            r_s_wb    <= in_wb;
            r_s_alu   <= in_alu;
            r_s_rdata <= in_rdata;
            r_s_dst   <= in_dst;
        end
    end

    assign out_valid = r_m_valid;
    assign out_wb    = r_m_wb;
    assign out_alu   = r_m_alu;
    assign out_rdata = r_m_rdata;
    assign out_dst   = r_m_dst;

    // Forwarding tap: wb[0] = RegWrite, wb[1] = MemToReg; r0 is never forwarded.
    assign fwd_valid = r_m_valid && r_m_wb[0] && (r_m_dst != '0);
    assign fwd_dst   = r_m_dst;
    assign fwd_data  = r_m_wb[1] ? r_m_rdata : r_m_alu;

    assign occupancy = 2'(r_m_valid) + 2'(r_s_valid);

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Testbench for mem_wb_pipe: directed table, hand sequences, random vs queue model.
module tb_mem_wb_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_wb;
    logic [31:0] in_alu;
    logic [31:0] in_rdata;
    logic [4:0]  in_dst;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_wb;
    logic [31:0] out_alu;
    logic [31:0] out_rdata;
    logic [4:0]  out_dst;
    logic        fwd_valid;
    logic [4:0]  fwd_dst;
    logic [31:0] fwd_data;
    logic [1:0]  occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    mem_wb_pipe #(.DATA_W(32), .REG_W(5), .WB_W(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_wb(in_wb), .in_alu(in_alu), .in_rdata(in_rdata), .in_dst(in_dst),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_wb(out_wb), .out_alu(out_alu), .out_rdata(out_rdata), .out_dst(out_dst),
        .fwd_valid(fwd_valid), .fwd_dst(fwd_dst), .fwd_data(fwd_data),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] alu;
        logic        ordy;
        logic        fl;
        logic        ov;
        logic [31:0] ealu;
        logic [1:0]  occ;
        logic        ir;
        logic        wbchk;
        logic [1:0]  ewb;
    } vec_t;

    typedef struct {
        logic [1:0]  wb;
        logic [4:0]  dst;
        logic [31:0] alu;
        logic [31:0] rdata;
    } ent_t;

    vec_t tbl[18];
    ent_t q[$];

    task automatic idle_inputs();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_wb = 2'b00; in_alu = '0; in_rdata = '0; in_dst = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Drive one entry and advance one edge.
    task automatic step(input logic iv, input logic [1:0] wb, input logic [4:0] dst,
                        input logic [31:0] alu, input logic [31:0] rd,
                        input logic ordy, input logic fl);
        in_valid = iv; in_wb = wb; in_dst = dst; in_alu = alu; in_rdata = rd;
        out_ready = ordy; flush = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();

        // Reset state while rst is held
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);
        chk("rst_fwd_dst", 64'(fwd_dst), 64'd0);
        chk("rst_fwd_data", 64'(fwd_data), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_out_alu", 64'(out_alu), 64'd0);
        chk("rst_out_wb", 64'(out_wb), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Directed table: stream, backpressure, flush
        tbl[0]  = '{1'b1, 32'h11, 1'b1, 1'b0, 1'b1, 32'h11, 2'd1, 1'b1, 1'b1, 2'b01};
        tbl[1]  = '{1'b1, 32'h22, 1'b1, 1'b0, 1'b1, 32'h22, 2'd1, 1'b1, 1'b1, 2'b01};
        tbl[2]  = '{1'b1, 32'h33, 1'b1, 1'b0, 1'b1, 32'h33, 2'd1, 1'b1, 1'b1, 2'b01};
        tbl[3]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1, 1'b0, 2'b00};
        tbl[4]  = '{1'b1, 32'hA1, 1'b0, 1'b0, 1'b1, 32'hA1, 2'd1, 1'b1, 1'b1, 2'b01};
        tbl[5]  = '{1'b1, 32'hA2, 1'b0, 1'b0, 1'b1, 32'hA1, 2'd2, 1'b0, 1'b1, 2'b01};
        tbl[6]  = '{1'b1, 32'hA3, 1'b0, 1'b0, 1'b1, 32'hA1, 2'd2, 1'b0, 1'b1, 2'b01};
        tbl[7]  = '{1'b1, 32'hA3, 1'b1, 1'b0, 1'b1, 32'hA2, 2'd1, 1'b1, 1'b1, 2'b01};
        tbl[8]  = '{1'b1, 32'hA3, 1'b1, 1'b0, 1'b1, 32'hA3, 2'd1, 1'b1, 1'b1, 2'b01};
        tbl[9]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1, 1'b0, 2'b00};
        tbl[10] = '{1'b1, 32'hB1, 1'b0, 1'b0, 1'b1, 32'hB1, 2'd1, 1'b1, 1'b1, 2'b01};
        tbl[11] = '{1'b1, 32'hB2, 1'b0, 1'b0, 1'b1, 32'hB1, 2'd2, 1'b0, 1'b1, 2'b01};
        tbl[12] = '{1'b1, 32'hB3, 1'b0, 1'b1, 1'b0, 32'h00, 2'd0, 1'b1, 1'b1, 2'b00};
        tbl[13] = '{1'b1, 32'hC1, 1'b0, 1'b0, 1'b1, 32'hC1, 2'd1, 1'b1, 1'b1, 2'b01};
        tbl[14] = '{1'b1, 32'hC2, 1'b0, 1'b1, 1'b0, 32'h00, 2'd0, 1'b1, 1'b1, 2'b00};
        tbl[15] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1, 1'b1, 2'b00};
        tbl[16] = '{1'b1, 32'hD1, 1'b1, 1'b0, 1'b1, 32'hD1, 2'd1, 1'b1, 1'b1, 2'b01};
        tbl[17] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1, 1'b0, 2'b00};

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].iv, 2'b01, 5'd3, tbl[i].alu, tbl[i].alu ^ 32'hFFFF0000,
                 tbl[i].ordy, tbl[i].fl);
            chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].ov));
            chk($sformatf("tbl%0d_occ", i), 64'(occupancy), 64'(tbl[i].occ));
            chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].ir));
            if (tbl[i].ov) begin
                chk($sformatf("tbl%0d_out_alu", i), 64'(out_alu), 64'(tbl[i].ealu));
                chk($sformatf("tbl%0d_out_rdata", i), 64'(out_rdata),
                    64'(tbl[i].ealu ^ 32'hFFFF0000));
                chk($sformatf("tbl%0d_out_dst", i), 64'(out_dst), 64'd3);
            end
            if (tbl[i].wbchk)
                chk($sformatf("tbl%0d_out_wb", i), 64'(out_wb), 64'(tbl[i].ewb));
        end

        // Forwarding tap
        step(1'b1, 2'b11, 5'd7, 32'h5, 32'h9, 1'b1, 1'b0);
        chk("fwd11_valid", 64'(fwd_valid), 64'd1);
        chk("fwd11_dst", 64'(fwd_dst), 64'd7);
        chk("fwd11_data", 64'(fwd_data), 64'h9);
        step(1'b1, 2'b01, 5'd7, 32'h5, 32'h9, 1'b1, 1'b0);
        chk("fwd01_valid", 64'(fwd_valid), 64'd1);
        chk("fwd01_data", 64'(fwd_data), 64'h5);
        step(1'b1, 2'b11, 5'd0, 32'h5, 32'h9, 1'b1, 1'b0);
        chk("fwd_r0_valid", 64'(fwd_valid), 64'd0);
        step(1'b1, 2'b10, 5'd7, 32'h5, 32'h9, 1'b1, 1'b0);
        chk("fwd_nowr_valid", 64'(fwd_valid), 64'd0);
        chk("fwd_nowr_data", 64'(fwd_data), 64'h9);
        step(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("fwd_empty_valid", 64'(fwd_valid), 64'd0);

        // Async reset mid-stall with two entries held
        step(1'b1, 2'b01, 5'd4, 32'hE0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 2'b01, 5'd5, 32'hE1, 32'h0, 1'b0, 1'b0);
        chk("ar_pre_occ", 64'(occupancy), 64'd2);
        chk("ar_pre_fwd", 64'(fwd_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_out_valid", 64'(out_valid), 64'd0);
        chk("ar_fwd_valid", 64'(fwd_valid), 64'd0);
        chk("ar_occ", 64'(occupancy), 64'd0);
        chk("ar_in_ready", 64'(in_ready), 64'd0);
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ar_rel_in_ready", 64'(in_ready), 64'd1);
        step(1'b1, 2'b01, 5'd6, 32'hF1, 32'h0, 1'b1, 1'b0);
        chk("ar_restart_valid", 64'(out_valid), 64'd1);
        chk("ar_restart_alu", 64'(out_alu), 64'hF1);
        step(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Random traffic against a FIFO model of up to two entries
        do_reset();
        q.delete();
        begin
            logic        p_stall;
            logic [31:0] p_alu;
            logic [31:0] p_rdata;
            logic [4:0]  p_dst;
            logic [1:0]  p_wb;
            p_stall = 1'b0;
            p_alu = '0; p_rdata = '0; p_dst = '0; p_wb = '0;
            for (int c = 0; c < 10000; c++) begin
                logic iv, ordy, fl;
                ent_t e;
                iv   = ($urandom_range(0, 9) < 7);
                ordy = ($urandom_range(0, 9) < 6);
                fl   = ($urandom_range(0, 99) < 3);
                e.wb    = 2'($urandom);
                e.dst   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                e.alu   = $urandom;
                e.rdata = $urandom;
                chk("rnd_in_ready", 64'(in_ready), 64'(q.size() < 2));
                step(iv, e.wb, e.dst, e.alu, e.rdata, ordy, fl);
                if (fl) begin
                    q.delete();
                end else begin
                    logic acc;
                    acc = iv && (q.size() < 2);
                    if (q.size() > 0 && ordy) void'(q.pop_front());
                    if (acc) q.push_back(e);
                end
                chk("rnd_occ", 64'(occupancy), 64'(q.size()));
                chk("rnd_out_valid", 64'(out_valid), 64'(q.size() > 0));
                if (q.size() > 0) begin
                    chk("rnd_out_alu", 64'(out_alu), 64'(q[0].alu));
                    chk("rnd_out_rdata", 64'(out_rdata), 64'(q[0].rdata));
                    chk("rnd_out_dst", 64'(out_dst), 64'(q[0].dst));
                    chk("rnd_out_wb", 64'(out_wb), 64'(q[0].wb));
                    chk("rnd_fwd_valid", 64'(fwd_valid),
                        64'(q[0].wb[0] && q[0].dst != 5'd0));
                    chk("rnd_fwd_dst", 64'(fwd_dst), 64'(q[0].dst));
                    chk("rnd_fwd_data", 64'(fwd_data),
                        64'(q[0].wb[1] ? q[0].rdata : q[0].alu));
                end else begin
                    chk("rnd_fwd_idle", 64'(fwd_valid), 64'd0);
                end
                if (fl) chk("rnd_flush_wb", 64'(out_wb), 64'd0);
                if (p_stall) begin
                    chk("rnd_stable_alu", 64'(out_alu), 64'(p_alu));
                    chk("rnd_stable_rdata", 64'(out_rdata), 64'(p_rdata));
                    chk("rnd_stable_dst", 64'(out_dst), 64'(p_dst));
                    chk("rnd_stable_wb", 64'(out_wb), 64'(p_wb));
                end
                // Next cycle's inputs decide the stall; capture what must stay stable.
                p_alu = out_alu; p_rdata = out_rdata; p_dst = out_dst; p_wb = out_wb;
                p_stall = 1'b0;
                if (q.size() > 0) begin
                    // Stall is only known once next cycle's inputs are chosen; check lazily.
                    p_stall = 1'b1;
                end
                // Peek: if the next cycle will not stall, the stability check is skipped.
                if (p_stall) begin
                    logic niv, nordy, nfl;
                    nordy = ($urandom_range(0, 9) < 6);
                    nfl   = ($urandom_range(0, 99) < 3);
                    niv   = ($urandom_range(0, 9) < 7);
                    if (nordy || nfl) p_stall = 1'b0;
                    if (!p_stall) continue;
                    // Forced stall cycle: hold out_ready low, no flush.
                    chk("rnd_in_ready", 64'(in_ready), 64'(q.size() < 2));
                    e.wb = 2'($urandom); e.dst = 5'($urandom);
                    e.alu = $urandom; e.rdata = $urandom;
                    step(niv, e.wb, e.dst, e.alu, e.rdata, 1'b0, 1'b0);
                    if (niv && q.size() < 2) q.push_back(e);
                    chk("rnd_occ", 64'(occupancy), 64'(q.size()));
                    chk("rnd_stable_alu", 64'(out_alu), 64'(p_alu));
                    chk("rnd_stable_rdata", 64'(out_rdata), 64'(p_rdata));
                    chk("rnd_stable_dst", 64'(out_dst), 64'(p_dst));
                    chk("rnd_stable_wb", 64'(out_wb), 64'(p_wb));
                    chk("rnd_stable_valid", 64'(out_valid), 64'd1);
                    p_stall = 1'b0;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
